// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-back entry layout.
package regfile_pkg;

  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_COUNT  = 16;

  // Bit positions within WRITE_ENABLE
  localparam int unsigned WE_PORT1 = 0;
  localparam int unsigned WE_PORT2 = 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending write-back entries for one source.
module wb_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Guards make overflow/underflow impossible regardless of the caller.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Dual-source write-back driver: ALU results go to port 1, memory results to
// port 2, with same-address heads serialised ALU first.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   A_VALID,
  output logic                   A_READY,
  input  logic [ADDR_W-1:0]      A_ADDR,
  input  logic [DATA_W-1:0]      A_DATA,
  input  logic                   B_VALID,
  output logic                   B_READY,
  input  logic [ADDR_W-1:0]      B_ADDR,
  input  logic [DATA_W-1:0]      B_DATA,
  input  logic                   HOLD,
  output logic [1:0]             WRITE_ENABLE,
  output logic [ADDR_W-1:0]      WRITE_ADDRESS1,
  output logic [ADDR_W-1:0]      WRITE_ADDRESS2,
  output logic [DATA_W-1:0]      WRITE_DATA1,
  output logic [DATA_W-1:0]      WRITE_DATA2,
  output logic [$clog2(DEPTH):0] A_COUNT,
  output logic [$clog2(DEPTH):0] B_COUNT,
  output logic                   BUSY
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0] a_head, b_head;
  logic               a_full, a_empty, b_full, b_empty;
  logic               a_push, b_push, a_go, b_go;
  logic [ADDR_W-1:0]  a_head_addr, b_head_addr;

  logic [1:0]         we_q, we_d;
  logic [ADDR_W-1:0]  addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DATA_W-1:0]  data1_q, data1_d, data2_q, data2_d;

  // Ready is held low throughout reset, then follows the registered count only.
  assign A_READY = RST && !a_full;
  assign B_READY = RST && !b_full;
  assign a_push  = A_VALID && A_READY;
  assign b_push  = B_VALID && B_READY;

  wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo_a (
    .CLK       (CLK),
    .RST       (RST),
    .push      (a_push),
    .push_data ({A_ADDR, A_DATA}),
    .pop       (a_go),
    .head      (a_head),
    .count     (A_COUNT),
    .full      (a_full),
    .empty     (a_empty)
  );

  wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo_b (
    .CLK       (CLK),
    .RST       (RST),
    .push      (b_push),
    .push_data ({B_ADDR, B_DATA}),
    .pop       (b_go),
    .head      (b_head),
    .count     (B_COUNT),
    .full      (b_full),
    .empty     (b_empty)
  );

  assign a_head_addr = a_head[DATA_W +: ADDR_W];
  assign b_head_addr = b_head[DATA_W +: ADDR_W];

  always_comb begin
    a_go = !a_empty && !HOLD;
    // Memory entry waits while the ALU head targets the same register.
    b_go = !b_empty && !HOLD && !(!a_empty && (a_head_addr == b_head_addr));

    we_d           = '0;
    we_d[WE_PORT1] = a_go;
    we_d[WE_PORT2] = b_go;

    addr1_d = addr1_q;
    data1_d = data1_q;
    addr2_d = addr2_q;
    data2_d = data2_q;
    if (a_go) begin
      addr1_d = a_head_addr;
      data1_d = a_head[DATA_W-1:0];
    end
    if (b_go) begin
      addr2_d = b_head_addr;
      data2_d = b_head[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      we_q    <= '0;
      addr1_q <= '0;
      data1_q <= '0;
      addr2_q <= '0;
      data2_q <= '0;
    end else begin
      we_q    <= we_d;
      addr1_q <= addr1_d;
      data1_q <= data1_d;
      addr2_q <= addr2_d;
      data2_q <= data2_d;
    end
  end

  assign WRITE_ENABLE   = we_q;
  assign WRITE_ADDRESS1 = addr1_q;
  assign WRITE_DATA1    = data1_q;
  assign WRITE_ADDRESS2 = addr2_q;
  assign WRITE_DATA2    = data2_q;
  assign BUSY           = (A_COUNT != '0) || (B_COUNT != '0) || (we_q != '0);

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus random
// traffic compared against a queue-based model of the write-back rules.
module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        A_VALID = 1'b0, B_VALID = 1'b0, HOLD = 1'b0;
  logic [3:0]  A_ADDR = '0, B_ADDR = '0;
  logic [15:0] A_DATA = '0, B_DATA = '0;
  logic        A_READY, B_READY, BUSY;
  logic [1:0]  WRITE_ENABLE;
  logic [3:0]  WRITE_ADDRESS1, WRITE_ADDRESS2;
  logic [15:0] WRITE_DATA1, WRITE_DATA2;
  logic [2:0]  A_COUNT, B_COUNT;

  int vectors = 0;
  int miscompares = 0;

  wb_entry_t   qa[$], qb[$];
  logic [1:0]  exp_we;
  logic [3:0]  exp_a1, exp_a2;
  logic [15:0] exp_d1, exp_d2;

  logic [50:0] dut_vec;
  assign dut_vec = {WRITE_ENABLE, WRITE_ADDRESS1, WRITE_DATA1, WRITE_ADDRESS2,
                    WRITE_DATA2, A_COUNT, B_COUNT, BUSY, A_READY, B_READY};

  regfile_writeback #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
    .HOLD(HOLD), .WRITE_ENABLE(WRITE_ENABLE),
    .WRITE_ADDRESS1(WRITE_ADDRESS1), .WRITE_ADDRESS2(WRITE_ADDRESS2),
    .WRITE_DATA1(WRITE_DATA1), .WRITE_DATA2(WRITE_DATA2),
    .A_COUNT(A_COUNT), .B_COUNT(B_COUNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [50:0] model_vec();
    logic busy, ardy, brdy;
    busy = (qa.size() != 0) || (qb.size() != 0) || (exp_we != 2'b00);
    ardy = RST && (qa.size() < DEPTH);
    brdy = RST && (qb.size() < DEPTH);
    return {exp_we, exp_a1, exp_d1, exp_a2, exp_d2,
            3'(qa.size()), 3'(qb.size()), busy, ardy, brdy};
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    exp_we = '0; exp_a1 = '0; exp_a2 = '0; exp_d1 = '0; exp_d2 = '0;
  endtask

  // Drive one cycle of stimulus from a negedge, advance the model across the
  // following posedge, and return at the next negedge.
  task automatic step(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                      input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                      input logic hold);
    logic a_acc, b_acc, a_go, b_go;
    wb_entry_t ea, eb;
    A_VALID = av; A_ADDR = aa; A_DATA = ad;
    B_VALID = bv; B_ADDR = ba; B_DATA = bd;
    HOLD = hold;
    a_acc = av && (qa.size() < DEPTH);
    b_acc = bv && (qb.size() < DEPTH);
    a_go  = (qa.size() != 0) && !hold;
    b_go  = (qb.size() != 0) && !hold &&
            !((qa.size() != 0) && (qa[0].addr == qb[0].addr));
    ea.addr = aa; ea.data = ad;
    eb.addr = ba; eb.data = bd;
    @(posedge CLK);
    exp_we = {b_go, a_go};
    if (a_go) begin
      exp_a1 = qa[0].addr; exp_d1 = qa[0].data;
      void'(qa.pop_front());
    end
    if (b_go) begin
      exp_a2 = qb[0].addr; exp_d2 = qb[0].data;
      void'(qb.pop_front());
    end
    if (a_acc) qa.push_back(ea);
    if (b_acc) qb.push_back(eb);
    @(negedge CLK);
  endtask

  task automatic idle(input logic hold);
    step(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, hold);
  endtask

  task automatic test_reset();
    model_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++;
    if (dut_vec !== 51'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", dut_vec, 51'd0);
    end
    RST = 1'b1;
    idle(1'b0);
    vectors++;
    if ({A_READY, B_READY, A_COUNT, B_COUNT, WRITE_ENABLE} !== {2'b11, 3'd0, 3'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b%b cnt=%0d/%0d we=%b want rdy=11 cnt=0/0 we=00",
               A_READY, B_READY, A_COUNT, B_COUNT, WRITE_ENABLE);
    end
  endtask

  task automatic test_single();
    step(1'b1, 4'ha, 16'hffff, 1'b0, 4'h0, 16'h0, 1'b0);
    vectors++;
    if (WRITE_ENABLE !== 2'b00 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL single_edge1: got we=%b busy=%b want we=00 busy=1", WRITE_ENABLE, BUSY);
    end
    idle(1'b0);
    vectors++;
    if ({WRITE_ENABLE, WRITE_ADDRESS1, WRITE_DATA1, BUSY} !== {2'b01, 4'ha, 16'hffff, 1'b1}) begin
      miscompares++;
      $display("FAIL single_write: got we=%b a1=%h d1=%h busy=%b want 01 a ffff 1",
               WRITE_ENABLE, WRITE_ADDRESS1, WRITE_DATA1, BUSY);
    end
    idle(1'b0);
    vectors++;
    if (WRITE_ENABLE !== 2'b00 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: got we=%b busy=%b want we=00 busy=0", WRITE_ENABLE, BUSY);
    end
  endtask

  task automatic test_dual();
    step(1'b1, 4'hb, 16'hffff, 1'b1, 4'h0, 16'habcd, 1'b0);
    idle(1'b0);
    vectors++;
    if ({WRITE_ENABLE, WRITE_ADDRESS1, WRITE_DATA1, WRITE_ADDRESS2, WRITE_DATA2} !==
        {2'b11, 4'hb, 16'hffff, 4'h0, 16'habcd}) begin
      miscompares++;
      $display("FAIL dual_write: got we=%b p1=%h/%h p2=%h/%h want 11 b/ffff 0/abcd",
               WRITE_ENABLE, WRITE_ADDRESS1, WRITE_DATA1, WRITE_ADDRESS2, WRITE_DATA2);
    end
    idle(1'b0);
    vectors++;
    if (WRITE_ENABLE !== 2'b00) begin
      miscompares++;
      $display("FAIL dual_after: got we=%b want 00", WRITE_ENABLE);
    end
  endtask

  task automatic test_conflict();
    step(1'b1, 4'h3, 16'h1111, 1'b1, 4'h3, 16'h2222, 1'b0);
    idle(1'b0);
    vectors++;
    if ({WRITE_ENABLE, WRITE_ADDRESS1, WRITE_DATA1} !== {2'b01, 4'h3, 16'h1111}) begin
      miscompares++;
      $display("FAIL conflict_first: got we=%b p1=%h/%h want 01 3/1111",
               WRITE_ENABLE, WRITE_ADDRESS1, WRITE_DATA1);
    end
    idle(1'b0);
    vectors++;
    if ({WRITE_ENABLE, WRITE_ADDRESS2, WRITE_DATA2} !== {2'b10, 4'h3, 16'h2222}) begin
      miscompares++;
      $display("FAIL conflict_second: got we=%b p2=%h/%h want 10 3/2222",
               WRITE_ENABLE, WRITE_ADDRESS2, WRITE_DATA2);
    end
    idle(1'b0);
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'(i + 5), 16'(16'h1000 + i), 1'b0, 4'h0, 16'h0, 1'b1);
      if (i == 3) begin
        vectors++;
        if (A_READY !== 1'b0 || A_COUNT !== 3'd4) begin
          miscompares++;
          $display("FAIL hold_full: got rdy=%b cnt=%0d want rdy=0 cnt=4", A_READY, A_COUNT);
        end
      end
    end
    vectors++;
    if (WRITE_ENABLE !== 2'b00 || A_COUNT !== 3'd4) begin
      miscompares++;
      $display("FAIL hold_blocked: got we=%b cnt=%0d want we=00 cnt=4", WRITE_ENABLE, A_COUNT);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      vectors++;
      if ({WRITE_ENABLE, WRITE_ADDRESS1, WRITE_DATA1} !== {2'b01, 4'(i + 5), 16'(16'h1000 + i)}) begin
        miscompares++;
        $display("FAIL hold_drain%0d: got we=%b p1=%h/%h want 01 %h/%h", i,
                 WRITE_ENABLE, WRITE_ADDRESS1, WRITE_DATA1, 4'(i + 5), 16'(16'h1000 + i));
      end
    end
    idle(1'b0);
    vectors++;
    if (A_READY !== 1'b1 || WRITE_ENABLE !== 2'b00 || A_COUNT !== 3'd0) begin
      miscompares++;
      $display("FAIL hold_done: got rdy=%b we=%b cnt=%0d want 1 00 0", A_READY, WRITE_ENABLE, A_COUNT);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) step(1'b1, 4'h1, 16'(i), 1'b0, 4'h0, 16'h0, 1'b1);
    step(1'b1, 4'h2, 16'h0bad, 1'b0, 4'h0, 16'h0, 1'b0);
    vectors++;
    if (A_COUNT !== 3'd3 || WRITE_ENABLE !== 2'b01) begin
      miscompares++;
      $display("FAIL fullpop_reject: got cnt=%0d we=%b want cnt=3 we=01", A_COUNT, WRITE_ENABLE);
    end
    step(1'b1, 4'h2, 16'h0600d, 1'b0, 4'h0, 16'h0, 1'b1);
    vectors++;
    if (A_COUNT !== 3'd4) begin
      miscompares++;
      $display("FAIL fullpop_accept: got cnt=%0d want 4", A_COUNT);
    end
    for (int i = 0; i < 6; i++) begin
      idle(1'b0);
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL fullpop_drain%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'(i), 16'(16'hA000 + i), 1'b1, 4'(i + 8), 16'(16'hB000 + i), 1'b1);
    idle(1'b0);
    vectors++;
    if (WRITE_ENABLE !== 2'b11 || A_COUNT !== 3'd2 || B_COUNT !== 3'd2) begin
      miscompares++;
      $display("FAIL rstmid_pre: got we=%b cnt=%0d/%0d want 11 2/2", WRITE_ENABLE, A_COUNT, B_COUNT);
    end
    #2 RST = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({WRITE_ENABLE, A_COUNT, B_COUNT, BUSY, A_READY, B_READY} !== 11'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: got we=%b cnt=%0d/%0d busy=%b rdy=%b%b want all 0",
               WRITE_ENABLE, A_COUNT, B_COUNT, BUSY, A_READY, B_READY);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      vectors++;
      if ({WRITE_ENABLE, A_COUNT, B_COUNT, BUSY, A_READY, B_READY} !== {2'b00, 3'd0, 3'd0, 1'b0, 2'b11}) begin
        miscompares++;
        $display("FAIL rstmid_after%0d: got we=%b cnt=%0d/%0d busy=%b rdy=%b%b want 00 0/0 0 11",
                 i, WRITE_ENABLE, A_COUNT, B_COUNT, BUSY, A_READY, B_READY);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic av, bv, hold;
      logic [3:0] aa, ba;
      logic [15:0] ad, bd;
      av = 1'($urandom_range(0, 1));
      bv = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0);
      aa = 4'($urandom_range(0, 3));
      ba = 4'($urandom_range(0, 3));
      ad = 16'($urandom);
      bd = 16'($urandom);
      step(av, aa, ad, bv, ba, bd, hold);
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL random%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL random_drain%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 4'(i), 16'(i * 3), 1'b1, 4'(i + 1), 16'(i * 7), 1'b0);
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL b2b%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
    for (int i = 0; i < 4; i++) idle(1'b0);
    vectors++;
    if (dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL b2b_drain: got %h want %h", dut_vec, model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_conflict();
    test_hold();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
